// File: rtl/cache_set.sv
// One index of an N_WAYS-way set-associative cache: tag lookup, byte-masked write hits,
// full-line fills, whole-set invalidate, true-LRU ages and a writeback victim view.
module cache_set #(
  parameter int N_WAYS           = 4,
  parameter int N_WORDS_PER_LINE = 8,
  parameter int TAG_SIZE         = 22
) (
  input  logic                             clk,
  input  logic                             rstn_i,
  input  logic                             req_i,
  input  logic [31:0]                      addr_i,
  input  logic                             we_i,
  input  logic [31:0]                      wdata_i,
  input  logic [3:0]                       be_i,
  input  logic                             fill_i,
  input  logic [N_WORDS_PER_LINE*32-1:0]   line_i,
  input  logic                             inval_i,
  output logic                             rvalid_o,
  output logic                             hit_o,
  output logic [31:0]                      rdata_o,
  output logic [$clog2(N_WAYS)-1:0]        victim_way_o,
  output logic                             victim_valid_o,
  output logic                             victim_dirty_o,
  output logic [TAG_SIZE-1:0]              victim_tag_o,
  output logic [N_WORDS_PER_LINE*32-1:0]   victim_line_o
);

  localparam int WAY_W  = $clog2(N_WAYS);
  localparam int WOFF   = $clog2(N_WORDS_PER_LINE);
  localparam int LINE_W = N_WORDS_PER_LINE * 32;

  logic [N_WAYS-1:0]   r_valid;
  logic [N_WAYS-1:0]   r_dirty;
  logic [TAG_SIZE-1:0] r_tag  [N_WAYS];
  logic [LINE_W-1:0]   r_line [N_WAYS];
  logic [WAY_W-1:0]    r_age  [N_WAYS];
  logic                r_rvalid;
  logic                r_hit;
  logic [31:0]         r_rdata;

  logic [TAG_SIZE-1:0] w_tag;
  logic [WOFF-1:0]     w_widx;
  logic [N_WAYS-1:0]   w_hit_vec;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic [WAY_W-1:0]    w_victim_way;
  logic                w_found_inv;
  logic [WAY_W-1:0]    w_fill_way;
  logic                w_do_req;
  logic                w_do_fill;
  logic                w_do_wr;
  logic                w_touch_en;
  logic [WAY_W-1:0]    w_touch_way;
  logic [WAY_W-1:0]    w_touch_age;
  logic [WAY_W-1:0]    w_age_next [N_WAYS];
  logic [LINE_W-1:0]   w_hit_line;
  logic [31:0]         w_rword;
  logic [LINE_W-1:0]   w_wline;
  logic                w_unused_addr;

  assign w_tag         = addr_i[31 -: TAG_SIZE];
  assign w_widx        = addr_i[WOFF+1:2];
  assign w_unused_addr = ^addr_i;

  // Invalidate outranks fill, which outranks a lookup.
  assign w_do_fill = fill_i & ~inval_i;
  assign w_do_req  = req_i & ~fill_i & ~inval_i;
  assign w_do_wr   = w_do_req & w_hit & we_i;

  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      w_hit_vec[w] = r_valid[w] && (r_tag[w] == w_tag);
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
    end
    w_hit = |w_hit_vec;
  end

  // Victim: lowest-index invalid way first, otherwise the oldest way.
  always_comb begin
    w_victim_way = '0;
    w_found_inv  = 1'b0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w]) begin
        w_victim_way = WAY_W'(w);
        w_found_inv  = 1'b1;
      end
    end
    if (!w_found_inv) begin
      for (int w = 0; w < N_WAYS; w++) begin
        if (r_age[w] == WAY_W'(N_WAYS - 1)) w_victim_way = WAY_W'(w);
      end
    end
  end

  // A fill refreshes an already-present tag instead of duplicating it.
  assign w_fill_way  = w_hit ? w_hit_way : w_victim_way;
  assign w_touch_en  = w_do_fill | (w_do_req & w_hit);
  assign w_touch_way = w_do_fill ? w_fill_way : w_hit_way;
  assign w_touch_age = r_age[w_touch_way];

  always_comb begin
    for (int w = 0; w < N_WAYS; w++) begin
      w_age_next[w] = r_age[w];
      if (w_touch_en) begin
        if (WAY_W'(w) == w_touch_way)      w_age_next[w] = '0;
        else if (r_age[w] < w_touch_age)   w_age_next[w] = r_age[w] + 1'b1;
      end
    end
  end

  assign w_hit_line = r_line[w_hit_way];
  assign w_rword    = w_hit_line[32*w_widx +: 32];

  always_comb begin
    w_wline = w_hit_line;
    for (int k = 0; k < 4; k++) begin
      if (be_i[k]) w_wline[32*w_widx + 8*k +: 8] = wdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid  <= '0;
      r_dirty  <= '0;
      r_rvalid <= 1'b0;
      r_hit    <= 1'b0;
      r_rdata  <= '0;
      for (int w = 0; w < N_WAYS; w++) begin
        r_tag[w]  <= '0;
        r_line[w] <= '0;
        r_age[w]  <= WAY_W'(w);
      end
    end else begin
      r_rvalid <= w_do_req;
      r_hit    <= w_do_req & w_hit;
      r_rdata  <= (w_do_req & w_hit) ? w_rword : '0;
      if (inval_i) begin
        r_valid <= '0;
        r_dirty <= '0;
        for (int w = 0; w < N_WAYS; w++) r_age[w] <= WAY_W'(w);
      end else begin
        for (int w = 0; w < N_WAYS; w++) r_age[w] <= w_age_next[w];
        if (w_do_fill) begin
          r_line[w_fill_way]  <= line_i;
          r_tag[w_fill_way]   <= w_tag;
          r_valid[w_fill_way] <= 1'b1;
          r_dirty[w_fill_way] <= 1'b0;
        end else if (w_do_wr) begin
          r_line[w_hit_way]  <= w_wline;
          r_dirty[w_hit_way] <= 1'b1;
        end
      end
    end
  end

  assign rvalid_o       = r_rvalid;
  assign hit_o          = r_hit;
  assign rdata_o        = r_rdata;
  assign victim_way_o   = w_victim_way;
  assign victim_valid_o = r_valid[w_victim_way];
  assign victim_dirty_o = r_dirty[w_victim_way];
  assign victim_tag_o   = r_tag[w_victim_way];
  assign victim_line_o  = r_line[w_victim_way];

endmodule

// File: doc/cache_set.md
Name: cache_set

Overview:
- N_WAYS-way set-associative storage for one cache index; successor to the single-line storage element.
- Performs tag lookup, word reads, byte-masked word writes on hit and full-line fills.
- Tracks per-way valid/dirty state and true-LRU ages, and exposes the current victim way for writeback.
- Sits between the cache controller FSM and the memory-side refill/writeback path; one instance per index.

Parameters:
- N_WAYS, 4, number of ways; power of two, 2..16.
- N_WORDS_PER_LINE, 8, 32-bit words per line; power of two, 2..64.
- TAG_SIZE, 22, tag bits taken from addr_i[31:32-TAG_SIZE].

Ports:
- clk  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  lookup request for addr_i.
- addr_i  in  32  request/fill address; word select = addr_i[WOFF+1:2], WOFF = clog2(N_WORDS_PER_LINE).
- we_i  in  1  qualifies req_i as a write.
- wdata_i  in  32  write word.
- be_i  in  4  byte enables for write.
- fill_i  in  1  install line_i for addr_i.
- line_i  in  N_WORDS_PER_LINE*32  refill data.
- inval_i  in  1  invalidate whole set.
- rvalid_o  out  1  lookup result valid (one-cycle pulse).
- hit_o  out  1  lookup hit, qualified by rvalid_o.
- rdata_o  out  32  addressed word on hit; 0 on miss.
- victim_way_o  out  clog2(N_WAYS)  current victim way.
- victim_valid_o  out  1  victim way valid.
- victim_dirty_o  out  1  victim way dirty.
- victim_tag_o  out  TAG_SIZE  victim tag.
- victim_line_o  out  N_WORDS_PER_LINE*32  victim data for writeback.

Behaviour:
- Reset: all valid=0, dirty=0, tags=0, data=0; age[w]=w. rvalid_o=0, hit_o=0, rdata_o=0. victim_* reflect way 0: way=0, valid=0, dirty=0, tag=0, line=0.
- Ages: always a permutation of 0..N_WAYS-1; 0 = most recent.
- Touching way w: every way with age < age[w] increments; age[w] becomes 0.
- Victim (combinational from registered state):
  - lowest-index invalid way if any invalid;
  - else the way with age = N_WAYS-1.
- Lookup, priority 3: req_i=1 with fill_i=0 and inval_i=0 at edge t.
  - Hit = valid && tag match on exactly one way.
  - At t+1: rvalid_o=1, hit_o, rdata_o = pre-write word of the hit way.
  - Hit way is touched.
  - Write hit (we_i=1): bytes with be_i[k]=1 are updated at edge t; dirty set. be_i=0 still marks dirty and touches.
  - Miss: no state change; rdata_o=0.
- Fill, priority 2: fill_i=1 with inval_i=0.
  - Target = way whose valid tag matches addr_i if any, else victim.
  - Target gets line_i, tag, valid=1, dirty=0; target touched.
  - A simultaneous req_i is dropped; rvalid_o stays 0 next cycle.
  - The victim must be read out before the fill edge. Fill does not write back; that is the controller's job.
- Invalidate, priority 1: inval_i=1.
  - All valid and dirty bits cleared; ages reset to age[w]=w; data and tags untouched.
  - Concurrent req_i and fill_i are dropped.
- rvalid_o and hit_o are single-cycle pulses; back-to-back requests produce back-to-back results.
- Reset mid-operation: the next cycle's result is discarded; rvalid_o=0 after reset.
- Tags are never duplicated, because fill matches existing ways first.

Test Plan:
- Reset then idle: victim_way_o=0, victim_valid_o=0, rvalid_o=0; req addr 0x1000 -> next cycle rvalid_o=1, hit_o=0, rdata_o=0.
- Fill addr 0x0000_0040 with words 0..7 = 0xA0..0xA7, then req addr 0x0000_004C -> rvalid_o=1, hit_o=1, rdata_o=0xA3; victim_way_o=1.
- Write hit addr 0x44, wdata 0x11223344, be_i=4'b0101 on word 0xA1 -> read returns 0x00220044 | 0xA1 upper bytes kept, i.e. 0x00220044 with bytes 1,3 from 0x000000A1 -> 0x00220044; dirty set for that way.
- Fill tags T0..T3 into ways 0..3, read T0, then fill T4 -> victim_way_o=1 before the fill; T1 is evicted; lookup T1 misses, lookup T0 hits.
- Write hit way 2, then make way 2 LRU -> victim_way_o=2, victim_dirty_o=1, victim_line_o shows the written bytes.
- fill_i and req_i in the same cycle -> rvalid_o=0 next cycle.
- inval_i asserted with fill_i -> all ways invalid, victim_way_o=0; later lookups miss.
- rstn_i asserted one cycle after req_i -> rvalid_o=0, set empty.
